// File: rtl/multi_channel_csa_accumulator.sv
// Multi-channel carry-save accumulator. Each channel keeps a redundant (sum, carry)
// pair; a terminate resolves one channel through a chunked carry-propagate adder,
// publishes the result and clears that channel.
module multi_channel_csa_accumulator #(
  parameter int unsigned INPUT_LENGTH  = 16,
  parameter int unsigned OUTPUT_LENGTH = 32,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned ADD_WIDTH     = 8,
  parameter int unsigned SIGNED        = 0,
  localparam int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iAccumulate,
  input  logic                     iTerminate,
  input  logic [CH_W-1:0]          iChannel,
  input  logic [INPUT_LENGTH-1:0]  iA,
  output logic                     oReady,
  output logic [OUTPUT_LENGTH-1:0] oRes,
  output logic [CH_W-1:0]          oChannel,
  output logic                     oDone
);

  localparam int unsigned NUM_CHUNKS = OUTPUT_LENGTH / ADD_WIDTH;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned AW1        = ADD_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StAcc, StResolve, StDone} state_e;

  state_e                   r_state, w_state_next;
  logic [OUTPUT_LENGTH-1:0] r_sum   [NUM_CHANNELS];
  logic [OUTPUT_LENGTH-1:0] r_carry [NUM_CHANNELS];
  logic [CH_W-1:0]          r_ch;
  logic [OUTPUT_LENGTH-1:0] r_a;
  logic [CNT_W-1:0]         r_chunk;
  logic                     r_cin;
  logic [OUTPUT_LENGTH-1:0] r_stage;
  logic [OUTPUT_LENGTH-1:0] r_res;
  logic [CH_W-1:0]          r_och;

  logic [OUTPUT_LENGTH-1:0] w_a_ext;
  logic                     w_ch_ok;
  logic                     w_last;
  logic [OUTPUT_LENGTH-1:0] w_sum_sel, w_carry_sel;
  logic [ADD_WIDTH-1:0]     w_s_chunk, w_c_chunk;
  logic [AW1-1:0]           w_add;
  logic [OUTPUT_LENGTH-1:0] w_stage_next;

  if (OUTPUT_LENGTH > INPUT_LENGTH) begin : g_ext
    assign w_a_ext = (SIGNED != 0) ?
        {{(OUTPUT_LENGTH-INPUT_LENGTH){iA[INPUT_LENGTH-1]}}, iA} :
        {{(OUTPUT_LENGTH-INPUT_LENGTH){1'b0}}, iA};
  end else begin : g_noext
    assign w_a_ext = iA;
  end

  assign w_ch_ok     = (32'(iChannel) < NUM_CHANNELS);
  assign w_last      = (r_chunk == CNT_W'(NUM_CHUNKS - 1));
  assign w_sum_sel   = r_sum[r_ch];
  assign w_carry_sel = r_carry[r_ch];

  // Pick the current chunk of the selected channel and add it with the running carry.
  always_comb begin
    w_s_chunk    = '0;
    w_c_chunk    = '0;
    w_stage_next = r_stage;
    for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
      if (r_chunk == CNT_W'(k)) begin
        w_s_chunk = w_sum_sel[k*ADD_WIDTH +: ADD_WIDTH];
        w_c_chunk = w_carry_sel[k*ADD_WIDTH +: ADD_WIDTH];
      end
    end
    w_add = AW1'(w_s_chunk) + AW1'(w_c_chunk) + AW1'(r_cin);
    for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
      if (r_chunk == CNT_W'(k)) begin
        w_stage_next[k*ADD_WIDTH +: ADD_WIDTH] = w_add[ADD_WIDTH-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  // Next-state decode; terminate wins over accumulate, bad channel indices are ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (iTerminate && w_ch_ok)       w_state_next = StResolve;
        else if (iAccumulate && w_ch_ok) w_state_next = StAcc;
      end
      StAcc:     w_state_next = StIdle;
      StResolve: if (w_last) w_state_next = StDone;
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Request latching and chunked resolve datapath.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_ch    <= '0;
      r_a     <= '0;
      r_chunk <= '0;
      r_cin   <= 1'b0;
      r_stage <= '0;
      r_res   <= '0;
      r_och   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_chunk <= '0;
          r_cin   <= 1'b0;
          if (w_ch_ok && (iTerminate || iAccumulate)) r_ch <= iChannel;
          if (w_ch_ok && !iTerminate && iAccumulate)  r_a  <= w_a_ext;
        end
        StResolve: begin
          r_stage <= w_stage_next;
          r_cin   <= w_add[ADD_WIDTH];
          r_chunk <= r_chunk + CNT_W'(1);
          // Publish on the last chunk so oRes is already valid while oDone is high.
          if (w_last) begin
            r_res <= w_stage_next;
            r_och <= r_ch;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel carry-save update on ACC, clear on DONE; other channels hold.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        r_sum[c]   <= '0;
        r_carry[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        if (r_ch == CH_W'(c)) begin
          if (r_state == StAcc) begin
            r_sum[c]   <= w_sum_sel ^ w_carry_sel ^ r_a;
            r_carry[c] <= ((w_sum_sel & w_carry_sel) | (w_sum_sel & r_a) |
                           (w_carry_sel & r_a)) << 1;
          end else if (r_state == StDone) begin
            r_sum[c]   <= '0;
            r_carry[c] <= '0;
          end
        end
      end
    end
  end

  assign oReady   = (r_state == StIdle);
  assign oDone    = (r_state == StDone);
  assign oRes     = r_res;
  assign oChannel = r_och;

endmodule

// File: tb/tb_multi_channel_csa_accumulator.sv
// Bench for multi_channel_csa_accumulator: unsigned/signed 32-bit pair and a narrow
// 8-bit pair (4-bit and 8-bit resolve chunks), checked against plain-arithmetic sums.
module tb_multi_channel_csa_accumulator;

  logic clk = 1'b0;
  logic rst;

  logic        m_acc, m_term;
  logic [1:0]  m_ch;
  logic [15:0] m_a;
  logic        u_ready, u_done, s_ready, s_done;
  logic [31:0] u_res, s_res;
  logic [1:0]  u_och, s_och;

  logic        n_acc, n_term;
  logic [1:0]  n_ch;
  logic [7:0]  n_a;
  logic        n4_ready, n4_done, n8_ready, n8_done;
  logic [7:0]  n4_res, n8_res;
  logic [1:0]  n4_och, n8_och;

  int passed = 0;
  int total  = 0;

  logic [31:0] ref_u [4];
  logic [31:0] ref_s [4];
  logic [7:0]  ref_n [4];

  logic [31:0] gu, gs;
  logic [7:0]  g4, g8;

  multi_channel_csa_accumulator #(.SIGNED(0)) u_dut (
    .iClk(clk), .iRst(rst), .iAccumulate(m_acc), .iTerminate(m_term), .iChannel(m_ch),
    .iA(m_a), .oReady(u_ready), .oRes(u_res), .oChannel(u_och), .oDone(u_done)
  );

  multi_channel_csa_accumulator #(.SIGNED(1)) u_sdut (
    .iClk(clk), .iRst(rst), .iAccumulate(m_acc), .iTerminate(m_term), .iChannel(m_ch),
    .iA(m_a), .oReady(s_ready), .oRes(s_res), .oChannel(s_och), .oDone(s_done)
  );

  multi_channel_csa_accumulator #(
    .INPUT_LENGTH(8), .OUTPUT_LENGTH(8), .ADD_WIDTH(4)
  ) u_n4 (
    .iClk(clk), .iRst(rst), .iAccumulate(n_acc), .iTerminate(n_term), .iChannel(n_ch),
    .iA(n_a), .oReady(n4_ready), .oRes(n4_res), .oChannel(n4_och), .oDone(n4_done)
  );

  multi_channel_csa_accumulator #(
    .INPUT_LENGTH(8), .OUTPUT_LENGTH(8), .ADD_WIDTH(8)
  ) u_n8 (
    .iClk(clk), .iRst(rst), .iAccumulate(n_acc), .iTerminate(n_term), .iChannel(n_ch),
    .iA(n_a), .oReady(n8_ready), .oRes(n8_res), .oChannel(n8_och), .oDone(n8_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_m();
    int n = 0;
    @(negedge clk);
    while (!(u_ready && s_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("m_ready", {31'b0, u_ready & s_ready}, 32'd1);
  endtask

  task automatic acc_m(input logic [1:0] ch, input logic [15:0] a);
    wait_m();
    m_acc = 1'b1; m_ch = ch; m_a = a;
    @(posedge clk); #1;
    m_acc = 1'b0;
    ref_u[ch] = ref_u[ch] + {16'b0, a};
    ref_s[ch] = ref_s[ch] + {{16{a[15]}}, a};
  endtask

  // Terminate ch (optionally with a simultaneous accumulate); while busy, pulse stray
  // requests at another channel that must have no effect.
  task automatic term_m(input logic [1:0] ch, input logic both,
                        output logic [31:0] ru, output logic [31:0] rs);
    int lat;
    wait_m();
    m_term = 1'b1; m_acc = both; m_ch = ch; m_a = 16'h0005;
    @(posedge clk); #1;
    lat = 1;
    m_term = 1'b1; m_acc = 1'b1; m_ch = ch ^ 2'd1; m_a = 16'($urandom);
    while (lat < 20 && !u_done) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin m_term = 1'b0; m_acc = 1'b0; end
    end
    m_term = 1'b0; m_acc = 1'b0;
    check("term_latency", 32'(lat), 32'd5);
    check("term_sdone", {31'b0, s_done}, 32'd1);
    check("term_res_u_model", u_res, ref_u[ch]);
    check("term_res_s_model", s_res, ref_s[ch]);
    check("term_och", {30'b0, u_och}, {30'b0, ch});
    ru = u_res; rs = s_res;
    ref_u[ch] = '0; ref_s[ch] = '0;
    @(posedge clk); #1;
    check("done_pulse_width", {31'b0, u_done | s_done}, 32'd0);
    check("res_hold", u_res, ru);
  endtask

  task automatic acc_n(input logic [1:0] ch, input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    while (!(n4_ready && n8_ready) && n < 50) begin @(negedge clk); n++; end
    check("n_ready", {31'b0, n4_ready & n8_ready}, 32'd1);
    n_acc = 1'b1; n_ch = ch; n_a = a;
    @(posedge clk); #1;
    n_acc = 1'b0;
    ref_n[ch] = ref_n[ch] + a;
  endtask

  task automatic term_n(input logic [1:0] ch, output logic [7:0] r4, output logic [7:0] r8);
    int n = 0;
    int l4 = 0;
    int l8 = 0;
    @(negedge clk);
    while (!(n4_ready && n8_ready) && n < 50) begin @(negedge clk); n++; end
    check("n_ready", {31'b0, n4_ready & n8_ready}, 32'd1);
    n_term = 1'b1; n_ch = ch;
    @(posedge clk); #1;
    n_term = 1'b0;
    r4 = '0; r8 = '0;
    for (int c = 1; c < 10; c++) begin
      if (n4_done && l4 == 0) begin
        l4 = c; r4 = n4_res;
        check("n4_och", {30'b0, n4_och}, {30'b0, ch});
      end
      if (n8_done && l8 == 0) begin
        l8 = c; r8 = n8_res;
        check("n8_och", {30'b0, n8_och}, {30'b0, ch});
      end
      @(posedge clk); #1;
    end
    check("n4_latency", 32'(l4), 32'd3);
    check("n8_latency", 32'(l8), 32'd2);
    check("n4_res_model", {24'b0, r4}, {24'b0, ref_n[ch]});
    check("n8_res_model", {24'b0, r8}, {24'b0, ref_n[ch]});
    ref_n[ch] = '0;
  endtask

  logic [15:0] seq [4];

  initial begin
    seq[0] = 16'h0701; seq[1] = 16'h00F1; seq[2] = 16'h10B7; seq[3] = 16'hA2C1;
    for (int c = 0; c < 4; c++) begin ref_u[c] = '0; ref_s[c] = '0; ref_n[c] = '0; end
    rst = 1'b1;
    m_acc = 1'b0; m_term = 1'b0; m_ch = '0; m_a = '0;
    n_acc = 1'b0; n_term = 1'b0; n_ch = '0; n_a = '0;
    #12;
    check("rst_ready", {31'b0, u_ready}, 32'd1);
    check("rst_done", {31'b0, u_done}, 32'd0);
    check("rst_res", u_res, 32'd0);
    check("rst_och", {30'b0, u_och}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Long sequence on ch0, then an empty terminate.
    for (int r = 0; r < 4; r++) for (int i = 0; i < 4; i++) acc_m(2'd0, seq[i]);
    term_m(2'd0, 1'b0, gu, gs);
    check("t1_res", gu, 32'h0002EDA8);
    term_m(2'd0, 1'b0, gu, gs);
    check("t1_empty", gu, 32'h0);

    // Interleaved channels.
    acc_m(2'd0, 16'h0701); acc_m(2'd1, 16'h00F1); acc_m(2'd0, 16'h10B7);
    term_m(2'd1, 1'b0, gu, gs); check("t2_ch1", gu, 32'h000000F1);
    term_m(2'd0, 1'b0, gu, gs); check("t2_ch0", gu, 32'h000017B8);
    term_m(2'd2, 1'b0, gu, gs); check("t2_ch2", gu, 32'h0);
    term_m(2'd3, 1'b0, gu, gs); check("t2_ch3", gu, 32'h0);

    // Signed versus unsigned extension.
    for (int i = 0; i < 4; i++) acc_m(2'd3, seq[i]);
    term_m(2'd3, 1'b0, gu, gs);
    check("t3_signed", gs, 32'hFFFFBB6A);
    check("t3_unsigned", gu, 32'h0000BB6A);

    // Terminate priority over a simultaneous accumulate.
    acc_m(2'd1, 16'h0010);
    term_m(2'd1, 1'b1, gu, gs); check("t5_prio", gu, 32'h00000010);
    term_m(2'd1, 1'b0, gu, gs); check("t5_dropped", gu, 32'h0);
    acc_m(2'd2, 16'h1234);
    term_m(2'd0, 1'b0, gu, gs);
    term_m(2'd2, 1'b0, gu, gs); check("t5_busy_ignored", gu, 32'h00001234);

    // Randomised traffic against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) term_m(2'($urandom_range(0, 3)), 1'b0, gu, gs);
      else acc_m(2'($urandom_range(0, 3)), 16'($urandom));
    end
    for (int c = 0; c < 4; c++) term_m(2'(c), 1'b0, gu, gs);

    // Narrow wrap-around with both chunk sizes.
    acc_n(2'd0, 8'hFF); acc_n(2'd0, 8'h02);
    term_n(2'd0, g4, g8);
    check("t4_n4_wrap", {24'b0, g4}, 32'h01);
    check("t4_n8_wrap", {24'b0, g8}, 32'h01);
    for (int i = 0; i < 12; i++) acc_n(2'($urandom_range(0, 3)), 8'($urandom));
    for (int c = 0; c < 4; c++) term_n(2'(c), g4, g8);

    // Reset in the middle of resolving.
    acc_m(2'd2, 16'hBEEF);
    wait_m();
    m_term = 1'b1; m_ch = 2'd2;
    @(posedge clk); #1;
    m_term = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_ready_async", {31'b0, u_ready}, 32'd1);
    check("t6_res_async", u_res, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t6_no_done", {31'b0, u_done | s_done}, 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin ref_u[c] = '0; ref_s[c] = '0; ref_n[c] = '0; end
    #1;
    check("t6_ready", {31'b0, u_ready}, 32'd1);
    check("t6_res", u_res, 32'd0);
    for (int c = 0; c < 4; c++) begin
      term_m(2'(c), 1'b0, gu, gs);
      check("t6_cleared", gu, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
